axi_riscv_amos_rmw_seq: RTL and testbench
=========================================

Name: axi_riscv_amos_rmw_seq

Overview:
- Read-modify-write sequencer for one AXI5 atomic (ATOP) request at a time, wrapping the combinational AMO ALU.
- Reads the target memory word, extracts and extends the operand lane, and drives the ALU.
- Merges the ALU result back into the word and writes it with byte strobes.
- Returns the old value. Sits between the AXI atomics front-end (request/response side) and the memory port.

Parameters:
ADDR_WIDTH, 64, request/memory address width
DATA_WIDTH, 64, memory word and ALU width in bits; power of two, >= 8
STRB_WIDTH, DATA_WIDTH/8, byte strobe width (derived, not overridable)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous reset, active-low
req_valid_i  in  1  AMO request valid
req_ready_o  out  1  AMO request ready
req_addr_i  in  ADDR_WIDTH  byte address
req_atop_i  in  6  AXI ATOP encoding
req_size_i  in  3  AXI size; access is 2^size bytes
req_operand_i  in  DATA_WIDTH  operand, right-aligned
rsp_valid_o  out  1  response valid
rsp_ready_i  in  1  response ready
rsp_data_o  out  DATA_WIDTH  old memory value, right-aligned and extended
rsp_error_o  out  1  request failed
mem_rd_valid_o  out  1  read request valid
mem_rd_ready_i  in  1  read request ready
mem_rd_addr_o  out  ADDR_WIDTH  word-aligned read address
mem_rd_rvalid_i  in  1  read data valid
mem_rd_rdata_i  in  DATA_WIDTH  read data
mem_rd_err_i  in  1  read error, qualified by rvalid
mem_wr_valid_o  out  1  write request valid
mem_wr_ready_i  in  1  write request ready
mem_wr_addr_o  out  ADDR_WIDTH  word-aligned write address
mem_wr_data_o  out  DATA_WIDTH  merged write word
mem_wr_strb_o  out  STRB_WIDTH  byte strobes
mem_wr_bvalid_i  in  1  write response valid
mem_wr_err_i  in  1  write error, qualified by bvalid
alu_op_o  out  6  ATOP to ALU
alu_operand_a_o  out  DATA_WIDTH  extended old value
alu_operand_b_o  out  DATA_WIDTH  extended operand
alu_result_i  in  DATA_WIDTH  ALU result, combinational on the above

Behaviour:
- Reset: FSM to IDLE; all registers cleared; all valid outputs 0, rsp_error_o 0, data/addr/strb outputs 0. Reset is asynchronous and active-low, so a reset mid-operation abandons the transaction immediately.
- FSM states: IDLE, RD_REQ, RD_WAIT, EXEC, WR_REQ, WR_WAIT, RSP.
- IDLE:
  - req_ready_o=1 only in IDLE. On handshake, latch address, ATOP, size and operand, then validate.
  - Valid requests go to RD_REQ.
  - Invalid requests go directly to RSP with error=1, data=0, and no memory access.
  - Invalid means any of: ATOP is not AtomicSwap (6'b110000) and top bits are not AtomicStore (01) or AtomicLoad (10) (this includes AtomicCompare and ATOP=0); 2^size > STRB_WIDTH; address not aligned to 2^size.
- RD_REQ: mem_rd_valid_o=1, address = addr with log2(STRB_WIDTH) LSBs cleared. On ready go to RD_WAIT.
- RD_WAIT: on rvalid, latch rdata.
  - If err: go to RSP with error=1, data=0, no write.
  - Otherwise go to EXEC.
- Lane extraction: lane offset = addr[log2(STRB_WIDTH)-1:0] bytes. Old value = rdata shifted right by offset*8 and masked to 2^size bytes.
- Extension rule:
  - Sign-extend both old value and operand to DATA_WIDTH when the op is SMAX (100) or SMIN (101) under AtomicLoad/AtomicStore.
  - Otherwise zero-extend.
  - The same rule applies to rsp_data_o.
- EXEC (one cycle): drive the ALU, then register the merged word.
  - Data: alu_result_i shifted left by offset*8.
  - Strobes: (2^size ones) shifted left by offset.
  - ALU ports are driven only in EXEC and are 0 otherwise.
  - Go to WR_REQ.
- WR_REQ: mem_wr_valid_o=1 with address, data and strobes held stable until ready, then go to WR_WAIT.
- WR_WAIT: on bvalid go to RSP; error = mem_wr_err_i; data = old value.
- RSP: rsp_valid_o=1 with data and error stable until rsp_ready_i, then return to IDLE. No new request is accepted in the same cycle.
- AtomicStore follows the same flow. Old data is still returned, and the consumer ignores it.
- Latency with zero-wait memories (ready=1, rvalid/bvalid in the cycle after their request handshake): rsp_valid_o rises 6 cycles after the request handshake. An invalid request responds 1 cycle after its handshake.
- Responses arriving in states other than RD_WAIT/WR_WAIT are ignored. At most one transaction is outstanding.

Test Plan:
- AtomicLoad ADD (6'b100000), size 2, addr 0x104, word 0x11111111_7FFFFFFF, operand 1 -> write data[63:32]=0x11111112, strb 0xF0, rsp_data 0x00000000_11111111, error 0, rsp_valid 6 cycles after accept.
- SMIN (6'b100101), size 2, addr 0x100, low lane 0xFFFFFFFE, operand 3 -> written lane 0xFFFFFFFE, strb 0x0F, rsp_data 0xFFFFFFFF_FFFFFFFE. Same stimulus with UMIN (6'b100111) -> written lane 0x00000003, rsp_data 0x00000000_FFFFFFFE.
- AtomicSwap, size 3, addr 0x200, old 0xDEADBEEF_CAFEF00D, operand 0x01234567_89ABCDEF -> write operand, strb 0xFF, rsp_data old value.
- Misaligned (size 2, addr 0x102), AtomicCompare (6'b110001), and size 4 -> no mem_rd_valid, rsp_error 1, rsp_data 0, 1-cycle response.
- mem_rd_err_i=1 -> no mem_wr_valid, error response. Also hold rsp_ready_i=0 for 5 cycles -> rsp held stable and req_ready_o stays 0.
- Assert rst_ni low during WR_WAIT -> all valids drop asynchronously. After release, an ADD request completes correctly.

Source files
------------

// File: rtl/axi_riscv_amos_rmw_seq.sv
// axi_riscv_amos_rmw_seq
//   Read-modify-write sequencer for a single AXI5 atomic (ATOP) request.
//   Reads the target word, extracts and extends the operand lane, drives the
//   external combinational AMO ALU for one cycle, merges the result back with
//   byte strobes, writes it, and returns the old (extended) lane value.
//
// Ports:
//   clk_i, rst_ni             clock, asynchronous active-low reset
//   req_*                     AMO request (valid/ready, addr, atop, size, operand)
//   rsp_*                     response (valid/ready, old data, error)
//   mem_rd_*                  read request channel and read data return
//   mem_wr_*                  write request channel and write response
//   alu_*                     ALU operation and operands, result returned comb.
module axi_riscv_amos_rmw_seq #(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned DATA_WIDTH = 64,
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [5:0]            req_atop_i,
  input  logic [2:0]            req_size_i,
  input  logic [DATA_WIDTH-1:0] req_operand_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_data_o,
  output logic                  rsp_error_o,
  output logic                  mem_rd_valid_o,
  input  logic                  mem_rd_ready_i,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr_o,
  input  logic                  mem_rd_rvalid_i,
  input  logic [DATA_WIDTH-1:0] mem_rd_rdata_i,
  input  logic                  mem_rd_err_i,
  output logic                  mem_wr_valid_o,
  input  logic                  mem_wr_ready_i,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wr_data_o,
  output logic [STRB_WIDTH-1:0] mem_wr_strb_o,
  input  logic                  mem_wr_bvalid_i,
  input  logic                  mem_wr_err_i,
  output logic [5:0]            alu_op_o,
  output logic [DATA_WIDTH-1:0] alu_operand_a_o,
  output logic [DATA_WIDTH-1:0] alu_operand_b_o,
  input  logic [DATA_WIDTH-1:0] alu_result_i
);

  localparam int unsigned LOG_STRB = $clog2(STRB_WIDTH);
  // Keep the lane-offset vector at least one bit wide for byte-wide memories.
  localparam int unsigned OFF_W    = (LOG_STRB > 0) ? LOG_STRB : 1;

  typedef enum logic [2:0] {
    IDLE, RD_REQ, RD_WAIT, EXEC, WR_REQ, WR_WAIT, RSP
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [5:0]            atop_q;
  logic [2:0]            size_q;
  logic [DATA_WIDTH-1:0] operand_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] wr_data_q;
  logic [STRB_WIDTH-1:0] wr_strb_q;
  logic [DATA_WIDTH-1:0] rsp_data_q;
  logic                  rsp_err_q;

  logic                  req_ok;
  logic                  sgn_op;
  logic [OFF_W-1:0]      offset;
  logic [ADDR_WIDTH-1:0] word_addr;
  logic [DATA_WIDTH-1:0] lane_raw;
  logic [DATA_WIDTH-1:0] old_ext;
  logic [DATA_WIDTH-1:0] opnd_ext;
  logic [STRB_WIDTH-1:0] strb_base;
  logic                  exec;

  // Supported: AtomicSwap, or any AtomicStore / AtomicLoad; access must fit
  // in one word and be naturally aligned.
  function automatic logic chk_req(input logic [ADDR_WIDTH-1:0] addr,
                                   input logic [5:0] atop,
                                   input logic [2:0] size);
    logic          atop_ok;
    logic          size_ok;
    logic          aligned;
    logic [OFF_W:0] lim;
    atop_ok = (atop == 6'b110000) || (atop[5:4] == 2'b01) || (atop[5:4] == 2'b10);
    size_ok = (32'(size) <= LOG_STRB);
    lim     = ((OFF_W+1)'(1) << size) - (OFF_W+1)'(1);
    aligned = ((addr[OFF_W-1:0] & lim[OFF_W-1:0]) == '0);
    return atop_ok && size_ok && aligned;
  endfunction

  // Bytes beyond the 2^sz-byte lane become zero or copies of the lane's sign.
  function automatic logic [DATA_WIDTH-1:0] extend(input logic [DATA_WIDTH-1:0] v,
                                                   input logic [2:0] sz,
                                                   input logic sgn);
    logic [DATA_WIDTH-1:0] r;
    logic [7:0]            byte_v;
    logic                  fill;
    r    = v;
    fill = 1'b0;
    for (int unsigned b = 0; b < STRB_WIDTH; b++) begin
      byte_v = v[b*8 +: 8];
      if (b + 1 == (32'd1 << sz)) fill = sgn & byte_v[7];
    end
    for (int unsigned b = 0; b < STRB_WIDTH; b++) begin
      if (b >= (32'd1 << sz)) r[b*8 +: 8] = {8{fill}};
    end
    return r;
  endfunction

  assign req_ok    = chk_req(req_addr_i, req_atop_i, req_size_i);
  assign sgn_op    = ((atop_q[5:4] == 2'b01) || (atop_q[5:4] == 2'b10)) &&
                     ((atop_q[2:0] == 3'b100) || (atop_q[2:0] == 3'b101));
  assign offset    = addr_q[OFF_W-1:0] & OFF_W'(STRB_WIDTH - 1);
  assign word_addr = addr_q & ~ADDR_WIDTH'(STRB_WIDTH - 1);
  assign lane_raw  = rdata_q >> {offset, 3'b000};
  assign old_ext   = extend(lane_raw, size_q, sgn_op);
  assign opnd_ext  = extend(operand_q, size_q, sgn_op);

  always_comb begin
    strb_base = '0;
    for (int unsigned b = 0; b < STRB_WIDTH; b++) begin
      strb_base[b] = (b < (32'd1 << size_q));
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid_i) state_d = req_ok ? RD_REQ : RSP;
      RD_REQ:  if (mem_rd_ready_i) state_d = RD_WAIT;
      RD_WAIT: if (mem_rd_rvalid_i) state_d = mem_rd_err_i ? RSP : EXEC;
      EXEC:    state_d = WR_REQ;
      WR_REQ:  if (mem_wr_ready_i) state_d = WR_WAIT;
      WR_WAIT: if (mem_wr_bvalid_i) state_d = RSP;
      RSP:     if (rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      atop_q     <= '0;
      size_q     <= '0;
      operand_q  <= '0;
      rdata_q    <= '0;
      wr_data_q  <= '0;
      wr_strb_q  <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            addr_q     <= req_addr_i;
            atop_q     <= req_atop_i;
            size_q     <= req_size_i;
            operand_q  <= req_operand_i;
            rsp_err_q  <= ~req_ok;
            rsp_data_q <= '0;
          end
        end
        RD_WAIT: begin
          if (mem_rd_rvalid_i) begin
            rdata_q <= mem_rd_rdata_i;
            if (mem_rd_err_i) rsp_err_q <= 1'b1;
          end
        end
        EXEC: begin
          wr_data_q <= alu_result_i << {offset, 3'b000};
          wr_strb_q <= strb_base << offset;
        end
        WR_WAIT: begin
          if (mem_wr_bvalid_i) begin
            rsp_err_q  <= mem_wr_err_i;
            rsp_data_q <= old_ext;
          end
        end
        default: ;
      endcase
    end
  end

  assign exec            = (state_q == EXEC);
  assign req_ready_o     = (state_q == IDLE);
  assign mem_rd_valid_o  = (state_q == RD_REQ);
  assign mem_wr_valid_o  = (state_q == WR_REQ);
  assign rsp_valid_o     = (state_q == RSP);
  assign rsp_data_o      = rsp_data_q;
  assign rsp_error_o     = rsp_err_q;
  assign mem_rd_addr_o   = word_addr;
  assign mem_wr_addr_o   = word_addr;
  assign mem_wr_data_o   = wr_data_q;
  assign mem_wr_strb_o   = wr_strb_q;
  assign alu_op_o        = exec ? atop_q   : '0;
  assign alu_operand_a_o = exec ? old_ext  : '0;
  assign alu_operand_b_o = exec ? opnd_ext : '0;

endmodule

// File: tb/tb_axi_riscv_amos_rmw_seq.sv
module tb_axi_riscv_amos_rmw_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready;
  logic [63:0] req_addr;
  logic [5:0]  req_atop;
  logic [2:0]  req_size;
  logic [63:0] req_operand;
  logic        rsp_valid, rsp_ready, rsp_error;
  logic [63:0] rsp_data;
  logic        mem_rd_valid, mem_rd_ready, mem_rd_rvalid, mem_rd_err;
  logic [63:0] mem_rd_addr, mem_rd_rdata;
  logic        mem_wr_valid, mem_wr_ready, mem_wr_bvalid, mem_wr_err;
  logic [63:0] mem_wr_addr, mem_wr_data;
  logic [7:0]  mem_wr_strb;
  logic [5:0]  alu_op;
  logic [63:0] alu_a, alu_b, alu_res;

  int checks = 0;
  int failures = 0;

  int          rd_cnt = 0;
  int          wr_cnt = 0;
  logic [63:0] rd_addr_seen, wr_addr_seen, wr_data_seen;
  logic [7:0]  wr_strb_seen;
  logic        b_block = 1'b0;

  always #5 clk = ~clk;

  axi_riscv_amos_rmw_seq #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
    .req_atop_i(req_atop), .req_size_i(req_size), .req_operand_i(req_operand),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
    .rsp_error_o(rsp_error),
    .mem_rd_valid_o(mem_rd_valid), .mem_rd_ready_i(mem_rd_ready), .mem_rd_addr_o(mem_rd_addr),
    .mem_rd_rvalid_i(mem_rd_rvalid), .mem_rd_rdata_i(mem_rd_rdata), .mem_rd_err_i(mem_rd_err),
    .mem_wr_valid_o(mem_wr_valid), .mem_wr_ready_i(mem_wr_ready), .mem_wr_addr_o(mem_wr_addr),
    .mem_wr_data_o(mem_wr_data), .mem_wr_strb_o(mem_wr_strb),
    .mem_wr_bvalid_i(mem_wr_bvalid), .mem_wr_err_i(mem_wr_err),
    .alu_op_o(alu_op), .alu_operand_a_o(alu_a), .alu_operand_b_o(alu_b),
    .alu_result_i(alu_res)
  );

  // Reference AMO ALU
  function automatic logic [63:0] alu_model(input logic [5:0] op, input logic [63:0] a,
                                            input logic [63:0] b);
    if (op[5:4] == 2'b11) return b;
    case (op[2:0])
      3'b000:  return a + b;
      3'b001:  return a & ~b;
      3'b010:  return a ^ b;
      3'b011:  return a | b;
      3'b100:  return ($signed(a) > $signed(b)) ? a : b;
      3'b101:  return ($signed(a) < $signed(b)) ? a : b;
      3'b110:  return (a > b) ? a : b;
      default: return (a < b) ? a : b;
    endcase
  endfunction

  assign alu_res = alu_model(alu_op, alu_a, alu_b);

  // Zero-wait memory: always ready, one-cycle rvalid/bvalid after handshake.
  always begin
    logic rd_hs, wr_hs;
    @(negedge clk);
    rd_hs = rst_n && mem_rd_valid && mem_rd_ready;
    wr_hs = rst_n && mem_wr_valid && mem_wr_ready;
    if (rd_hs) begin
      rd_cnt++;
      rd_addr_seen = mem_rd_addr;
    end
    if (wr_hs) begin
      wr_cnt++;
      wr_addr_seen = mem_wr_addr;
      wr_data_seen = mem_wr_data;
      wr_strb_seen = mem_wr_strb;
    end
    @(posedge clk);
    #1;
    mem_rd_rvalid = rd_hs;
    mem_wr_bvalid = wr_hs && !b_block;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] strb_mask(input logic [7:0] s);
    logic [63:0] m;
    m = '0;
    for (int b = 0; b < 8; b++) if (s[b]) m[b*8 +: 8] = 8'hFF;
    return m;
  endfunction

  typedef struct {
    logic [5:0]  atop;
    logic [2:0]  size;
    logic [63:0] addr;
    logic [63:0] word;
    logic [63:0] operand;
    logic [63:0] exp_wr_data;
    logic [7:0]  exp_strb;
    logic [63:0] exp_rsp;
    logic        exp_err;
    int          exp_lat;
    logic        exp_mem;
  } vec_t;

  vec_t vecs [10];

  // Issue one request; lat counts cycles from the handshake cycle to rsp_valid.
  task automatic send_req(input logic [5:0] atop, input logic [2:0] size,
                          input logic [63:0] addr, input logic [63:0] opnd,
                          output int lat);
    int guard;
    @(negedge clk);
    req_atop = atop; req_size = size; req_addr = addr; req_operand = opnd;
    req_valid = 1'b1;
    guard = 0;
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int lat, rd0, wr0;
    logic [63:0] m;
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    mem_rd_rdata = v.word;
    mem_rd_err = 1'b0;
    send_req(v.atop, v.size, v.addr, v.operand, lat);
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd1);
    chk({tag, "_latency"}, 64'(lat), 64'(v.exp_lat));
    chk({tag, "_rsp_data"}, rsp_data, v.exp_rsp);
    chk({tag, "_rsp_error"}, 64'(rsp_error), 64'(v.exp_err));
    chk({tag, "_rd_count"}, 64'(rd_cnt - rd0), 64'(v.exp_mem));
    chk({tag, "_wr_count"}, 64'(wr_cnt - wr0), 64'(v.exp_mem));
    if (v.exp_mem) begin
      m = strb_mask(v.exp_strb);
      chk({tag, "_wr_data"}, wr_data_seen & m, v.exp_wr_data & m);
      chk({tag, "_wr_strb"}, 64'(wr_strb_seen), 64'(v.exp_strb));
      chk({tag, "_rd_addr"}, rd_addr_seen, v.addr & ~64'h7);
      chk({tag, "_wr_addr"}, wr_addr_seen, v.addr & ~64'h7);
    end
    @(posedge clk);
    #1;
    chk({tag, "_rsp_done"}, 64'(rsp_valid), 64'd0);
    chk({tag, "_ready_again"}, 64'(req_ready), 64'd1);
  endtask

  initial begin
    int lat, rd0, wr0, guard;

    //          atop      sz    addr        word                    operand                 wr_data                 strb   rsp                     err lat mem
    vecs[0] = '{6'b100000, 3'd2, 64'h104, 64'h11111111_7FFFFFFF, 64'h1,                64'h11111112_00000000, 8'hF0, 64'h00000000_11111111, 1'b0, 6, 1'b1};
    vecs[1] = '{6'b100101, 3'd2, 64'h100, 64'hAAAAAAAA_FFFFFFFE, 64'h3,                64'h00000000_FFFFFFFE, 8'h0F, 64'hFFFFFFFF_FFFFFFFE, 1'b0, 6, 1'b1};
    vecs[2] = '{6'b100111, 3'd2, 64'h100, 64'hAAAAAAAA_FFFFFFFE, 64'h3,                64'h00000000_00000003, 8'h0F, 64'h00000000_FFFFFFFE, 1'b0, 6, 1'b1};
    vecs[3] = '{6'b110000, 3'd3, 64'h200, 64'hDEADBEEF_CAFEF00D, 64'h01234567_89ABCDEF, 64'h01234567_89ABCDEF, 8'hFF, 64'hDEADBEEF_CAFEF00D, 1'b0, 6, 1'b1};
    vecs[4] = '{6'b100000, 3'd2, 64'h102, 64'h55555555_55555555, 64'h1,                64'h0,                 8'h00, 64'h0,                 1'b1, 1, 1'b0};
    vecs[5] = '{6'b110001, 3'd2, 64'h100, 64'h55555555_55555555, 64'h1,                64'h0,                 8'h00, 64'h0,                 1'b1, 1, 1'b0};
    vecs[6] = '{6'b100000, 3'd4, 64'h100, 64'h55555555_55555555, 64'h1,                64'h0,                 8'h00, 64'h0,                 1'b1, 1, 1'b0};
    vecs[7] = '{6'b000000, 3'd2, 64'h100, 64'h55555555_55555555, 64'h1,                64'h0,                 8'h00, 64'h0,                 1'b1, 1, 1'b0};
    vecs[8] = '{6'b010100, 3'd0, 64'h103, 64'h12345678_80ABCDEF, 64'h05,               64'h00000000_05000000, 8'h08, 64'hFFFFFFFF_FFFFFF80, 1'b0, 6, 1'b1};
    vecs[9] = '{6'b100010, 3'd1, 64'h106, 64'hBEEF0000_00000000, 64'h1111,             64'hAFFE0000_00000000, 8'hC0, 64'h00000000_0000BEEF, 1'b0, 6, 1'b1};

    rst_n = 1'b0;
    req_valid = 1'b0; req_addr = '0; req_atop = '0; req_size = '0; req_operand = '0;
    rsp_ready = 1'b1;
    mem_rd_ready = 1'b1; mem_rd_rvalid = 1'b0; mem_rd_rdata = '0; mem_rd_err = 1'b0;
    mem_wr_ready = 1'b1; mem_wr_bvalid = 1'b0; mem_wr_err = 1'b0;

    #22;
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rd_valid", 64'(mem_rd_valid), 64'd0);
    chk("rst_wr_valid", 64'(mem_wr_valid), 64'd0);
    chk("rst_rsp_error", 64'(rsp_error), 64'd0);
    chk("rst_rsp_data", rsp_data, 64'd0);
    chk("rst_wr_strb", 64'(mem_wr_strb), 64'd0);
    chk("rst_alu_a", alu_a, 64'd0);
    chk("rst_alu_op", 64'(alu_op), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) run_vec(vecs[i], $sformatf("v%0d", i));
    chk("idle_alu_b", alu_b, 64'd0);

    // Read error with a stalled response consumer.
    rd0 = rd_cnt; wr0 = wr_cnt;
    mem_rd_rdata = 64'h0123_4567_89AB_CDEF;
    mem_rd_err = 1'b1;
    rsp_ready = 1'b0;
    send_req(6'b100000, 3'd2, 64'h108, 64'h1, lat);
    mem_rd_err = 1'b0;
    chk("rderr_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("rderr_latency", 64'(lat), 64'd3);
    chk("rderr_error", 64'(rsp_error), 64'd1);
    chk("rderr_data", rsp_data, 64'd0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      req_valid = 1'b1;
      @(posedge clk);
      #1;
      chk($sformatf("hold%0d_rsp_valid", c), 64'(rsp_valid), 64'd1);
      chk($sformatf("hold%0d_error", c), 64'(rsp_error), 64'd1);
      chk($sformatf("hold%0d_data", c), rsp_data, 64'd0);
      chk($sformatf("hold%0d_req_ready", c), 64'(req_ready), 64'd0);
    end
    @(negedge clk);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("rderr_rsp_done", 64'(rsp_valid), 64'd0);
    chk("rderr_rd_count", 64'(rd_cnt - rd0), 64'd1);
    chk("rderr_wr_count", 64'(wr_cnt - wr0), 64'd0);

    // Asynchronous reset while waiting for the write response.
    b_block = 1'b1;
    wr0 = wr_cnt;
    mem_rd_rdata = vecs[0].word;
    @(negedge clk);
    req_atop = vecs[0].atop; req_size = vecs[0].size;
    req_addr = vecs[0].addr; req_operand = vecs[0].operand;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    guard = 0;
    while (wr_cnt == wr0 && guard < 20) begin
      @(posedge clk);
      #1;
      guard++;
    end
    chk("rst_mid_reached_wr", 64'(wr_cnt - wr0), 64'd1);
    @(posedge clk);
    #1;
    chk("wrwait_strb_held", 64'(mem_wr_strb), 64'hF0);
    chk("wrwait_ready_low", 64'(req_ready), 64'd0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_wr_valid", 64'(mem_wr_valid), 64'd0);
    chk("rst_mid_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_mid_rd_valid", 64'(mem_rd_valid), 64'd0);
    chk("rst_mid_wr_strb", 64'(mem_wr_strb), 64'd0);
    chk("rst_mid_wr_data", mem_wr_data, 64'd0);
    chk("rst_mid_req_ready", 64'(req_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    b_block = 1'b0;
    run_vec(vecs[0], "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
